ma_stage_param: RTL and testbench
=================================

Name: ma_stage_param

Overview:
- Parametrised, clocked successor to the memory-access stage of the data-driven pipeline.
- Accepts one token per CP edge over a Send/Ack handshake and performs one of four operations on a local data memory: pass, load, store or fetch-add.
- Emits the token downstream, with load data merged into the low field, after one registered stage with backpressure.
- Sits between the execute stage and the token-matching / output stage.

Parameters:
PKT_W, 40, packet width; the low DATA_W bits are the result/address field.
DATA_W, 16, data-memory word width and merge-field width.
ADDR_W, 10, number of low packet bits used as the memory address (ADDR_W <= DATA_W).
DEPTH, 1024, number of memory words; may be less than 2^ADDR_W.
CLEAR_ON_RESET, 1, 1 = MR zeroes every memory word; 0 = memory contents survive MR.

Ports:
CP  in  1  clock; all state changes on its rising edge
MR  in  1  reset, synchronous, active-high
Send_in  in  1  upstream token valid
Ack_out  out  1  stage can accept; a transfer happens on a CP edge with Send_in && Ack_out
OP  in  2  operation: 00 pass, 01 load, 10 store, 11 fetch-add; sampled with the token
WRITE_DATA  in  DATA_W  store value or fetch-add addend; sampled with the token
PACKET_IN  in  PKT_W  token; address = PACKET_IN[ADDR_W-1:0]
Send_out  out  1  output token valid
Ack_in  in  1  downstream accepts; an output transfer happens with Send_out && Ack_in
PACKET_OUT  out  PKT_W  result token
ADDR_ERR  out  1  qualifies PACKET_OUT: load/store/fetch-add addressed >= DEPTH

Behaviour:
- Reset: a CP edge with MR=1 clears the output register, error flag, RMW pending flag and read register. Send_out=0, PACKET_OUT=0, ADDR_ERR=0, Ack_out=1 after that edge. With CLEAR_ON_RESET=1 all DEPTH words are also 0. MR overrides every other action on that edge, including an accepted token, a pending write and an in-flight output.
- Ack_out = !rmw_pend && (!Send_out || Ack_in), combinational.
- Accept edge:
  - Token, OP and error flag are registered.
  - Memory is read synchronously at the address (read register updated only on accept).
  - Store writes WRITE_DATA at the same edge.
  - Send_out=1 from the next cycle, so latency is one cycle.
- Output holds stable while Send_out && !Ack_in. Accept and drain on the same edge are allowed, giving full throughput of 1 token per cycle for pass, load and store.
- PACKET_OUT:
  - load and fetch-add: {PACKET_IN[PKT_W-1:DATA_W], rdata}.
  - pass and store: PACKET_IN unchanged.
  - fetch-add returns the OLD memory value.
- Fetch-add:
  - Accept edge reads the old value and sets rmw_pend.
  - The next edge writes (old + WRITE_DATA) mod 2^DATA_W and clears rmw_pend.
  - Ack_out=0 during the rmw_pend cycle, a mandatory one-cycle bubble, so the single write port never conflicts.
  - A token accepted after the bubble sees the updated value. The write completes even if the output is stalled.
- Out of range (address >= DEPTH) for load, store or fetch-add:
  - No memory write.
  - Merged data = 0.
  - rmw_pend is not set, so there is no bubble.
  - ADDR_ERR=1 with that token.
  - Pass never flags an error.
- Store then load to the same address on consecutive accepts: the load returns the stored value, because the write lands on the earlier edge.
- ADDR_ERR is registered with the token and held while stalled.

Test Plan:
1. MR=1 for one edge after random traffic -> Send_out=0, PACKET_OUT=0, Ack_out=1; with CLEAR_ON_RESET=1, a load of address 5 returns low field 0x0000.
2. Store 0xBEEF to address 0x012, then a back-to-back load with PACKET_IN=0xA5A5A50012 -> PACKET_OUT=0xA5A5A5BEEF one cycle after accept, ADDR_ERR=0.
3. Memory[7]=0xFFFE, fetch-add WRITE_DATA=3 at address 7 -> output low field 0xFFFE; Ack_out=0 for exactly one cycle; a following load of address 7 returns 0x0001 (wrap).
4. Ack_in=0 for 4 cycles with a token held -> PACKET_OUT stable, Ack_out=0, no new accept. Ack_in=1 with Send_in=1 continuously -> one token per cycle, order preserved.
5. DEPTH=1000: store 0x1234 to address 1000 -> ADDR_ERR=1, token passes; load of address 1000 -> low field 0x0000 with ADDR_ERR=1; pass of address 1000 -> ADDR_ERR=0.
6. MR asserted in the bubble cycle after a fetch-add to address 3 (old 0x0010, addend 1), CLEAR_ON_RESET=0 -> write suppressed; a later load of address 3 returns 0x0010.

Source files
------------

// File: rtl/ma_stage_param.sv
// Memory-access pipeline stage: pass/load/store/fetch-add on a local data memory,
// one registered output slot with Send/Ack handshaking on both sides.
module ma_stage_param #(
  parameter int PKT_W          = 40,
  parameter int DATA_W         = 16,
  parameter int ADDR_W         = 10,
  parameter int DEPTH          = 1024,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              CP,
  input  logic              MR,
  input  logic              Send_in,
  output logic              Ack_out,
  input  logic [1:0]        OP,
  input  logic [DATA_W-1:0] WRITE_DATA,
  input  logic [PKT_W-1:0]  PACKET_IN,
  output logic              Send_out,
  input  logic              Ack_in,
  output logic [PKT_W-1:0]  PACKET_OUT,
  output logic              ADDR_ERR
);

  // state     | meaning
  // ST_READY  | no read-modify-write outstanding; tokens may be accepted
  // ST_RMW_WB | fetch-add write-back cycle; input stalled for one bubble
  typedef enum logic {ST_READY, ST_RMW_WB} state_e;

  localparam int          IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  localparam logic [1:0] OP_PASS  = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [1:0] OP_FADD  = 2'b11;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  state_e            state_q, state_d;
  logic              rmw_pend;
  logic [ADDR_W-1:0] in_addr;
  logic [IDX_W-1:0]  in_idx;
  logic              in_range;
  logic              accept;
  logic              start_rmw;
  logic              addr_err_in;

  logic              send_q;
  logic [PKT_W-1:0]  pkt_q;
  logic [1:0]        op_q;
  logic              err_q;
  logic [DATA_W-1:0] rdata_q;
  logic [IDX_W-1:0]  rmw_idx_q;
  logic [DATA_W-1:0] rmw_add_q;
  logic [DATA_W-1:0] rmw_sum;

  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] wr_data;

  assign in_addr     = PACKET_IN[ADDR_W-1:0];
  assign in_idx      = in_addr[IDX_W-1:0];
  assign in_range    = (32'(in_addr) < DEPTH_U);
  assign rmw_pend    = (state_q == ST_RMW_WB);
  assign Ack_out     = !rmw_pend && (!send_q || Ack_in);
  assign accept      = Send_in && Ack_out;
  assign addr_err_in = (OP != OP_PASS) && !in_range;
  assign start_rmw   = accept && (OP == OP_FADD) && in_range;
  assign rmw_sum     = rdata_q + rmw_add_q;

  always_ff @(posedge CP) begin
    if (MR) state_q <= ST_READY;
    else    state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_READY:  if (start_rmw) state_d = ST_RMW_WB;
      ST_RMW_WB: state_d = ST_READY;
      default:   state_d = ST_READY;
    endcase
  end

  // Single write port: the fetch-add write-back owns it during the bubble,
  // otherwise an in-range store writes on its accept edge.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = in_idx;
    wr_data = WRITE_DATA;
    if (rmw_pend) begin
      wr_en   = 1'b1;
      wr_idx  = rmw_idx_q;
      wr_data = rmw_sum;
    end else if (accept && (OP == OP_STORE) && in_range) begin
      wr_en = 1'b1;
    end
  end

  always_ff @(posedge CP) begin
    if (MR) begin
      if (CLEAR_ON_RESET != 0) begin
        for (int i = 0; i < DEPTH; i++) mem[IDX_W'(i)] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge CP) begin
    if (MR) begin
      send_q    <= 1'b0;
      pkt_q     <= '0;
      op_q      <= OP_PASS;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      rmw_idx_q <= '0;
      rmw_add_q <= '0;
    end else begin
      if (accept) begin
        send_q  <= 1'b1;
        pkt_q   <= PACKET_IN;
        op_q    <= OP;
        err_q   <= addr_err_in;
        rdata_q <= in_range ? mem[in_idx] : '0;
      end else if (Ack_in) begin
        send_q <= 1'b0;
      end
      if (start_rmw) begin
        rmw_idx_q <= in_idx;
        rmw_add_q <= WRITE_DATA;
      end
    end
  end

  assign Send_out   = send_q;
  assign ADDR_ERR   = err_q;
  assign PACKET_OUT = ((op_q == OP_LOAD) || (op_q == OP_FADD)) ?
                      {pkt_q[PKT_W-1:DATA_W], rdata_q} : pkt_q;

endmodule

// File: tb/tb_ma_stage_param.sv
// Bench for ma_stage_param: two instances (DEPTH=1000 clearing, DEPTH=1024 retaining)
// share stimulus; each is compared against its own queue/array reference model.
module tb_ma_stage_param;

  localparam logic [1:0] PASS = 2'b00, LOAD = 2'b01, STORE = 2'b10, FADD = 2'b11;

  logic        CP = 1'b0;
  logic        mr, send_in, ack_in;
  logic [1:0]  op;
  logic [15:0] wd;
  logic [39:0] pkt_in;

  logic        ack_a, send_a, err_a, ack_b, send_b, err_b;
  logic [39:0] pkt_a, pkt_b;

  always #5 CP = ~CP;

  ma_stage_param #(.PKT_W(40), .DATA_W(16), .ADDR_W(10), .DEPTH(1000), .CLEAR_ON_RESET(1)) ua (
    .CP(CP), .MR(mr), .Send_in(send_in), .Ack_out(ack_a), .OP(op), .WRITE_DATA(wd),
    .PACKET_IN(pkt_in), .Send_out(send_a), .Ack_in(ack_in), .PACKET_OUT(pkt_a), .ADDR_ERR(err_a));

  ma_stage_param #(.PKT_W(40), .DATA_W(16), .ADDR_W(10), .DEPTH(1024), .CLEAR_ON_RESET(0)) ub (
    .CP(CP), .MR(mr), .Send_in(send_in), .Ack_out(ack_b), .OP(op), .WRITE_DATA(wd),
    .PACKET_IN(pkt_in), .Send_out(send_b), .Ack_in(ack_in), .PACKET_OUT(pkt_b), .ADDR_ERR(err_b));

  typedef struct packed {logic [39:0] pkt; logic err;} tok_t;

  int          nvec = 0, nerr = 0;
  logic [15:0] mmem [2][1024];
  tok_t        mq [2][$];
  int          depth_m [2] = '{1000, 1024};
  bit          clear_m [2] = '{1'b1, 1'b0};
  bit          bub [2], fresh [2], exp_acc [2];
  int          pa [2];
  logic [15:0] pw [2];

  task automatic chk(input string tag, input int k, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s[%0d]: observed %h expected %h", tag, k, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      bit ea;
      ea = !bub[k] && (mq[k].size() == 0 || ack_in);
      chk("send_out", k, k ? send_b : send_a, mq[k].size() != 0);
      chk("ack_out", k, k ? ack_b : ack_a, ea);
      if (mq[k].size() != 0) begin
        chk("packet_out", k, k ? pkt_b : pkt_a, mq[k][0].pkt);
        chk("addr_err", k, k ? err_b : err_a, mq[k][0].err);
      end else if (fresh[k]) begin
        chk("reset_packet", k, k ? pkt_b : pkt_a, 0);
        chk("reset_err", k, k ? err_b : err_a, 0);
      end
      exp_acc[k] = send_in && ea;
    end
  endtask

  // Behavioural view of one clock edge: memory as an array, output slot as a queue.
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (mr) begin
        mq[k].delete();
        bub[k] = 0;
        fresh[k] = 1;
        if (clear_m[k]) for (int i = 0; i < 1024; i++) mmem[k][i] = 16'h0;
      end else begin
        if (bub[k]) begin
          mmem[k][pa[k]] = mmem[k][pa[k]] + pw[k];
          bub[k] = 0;
        end
        if (mq[k].size() != 0 && ack_in) void'(mq[k].pop_front());
        if (exp_acc[k]) begin
          int a;
          bit inr;
          logic [15:0] d;
          tok_t t;
          a   = int'(pkt_in[9:0]);
          inr = a < depth_m[k];
          d   = inr ? mmem[k][a] : 16'h0;
          t.pkt = pkt_in;
          t.err = (op != PASS) && !inr;
          if (op == LOAD || op == FADD) t.pkt = {pkt_in[39:16], d};
          if (op == STORE && inr) mmem[k][a] = wd;
          if (op == FADD && inr) begin
            bub[k] = 1;
            pa[k]  = a;
            pw[k]  = wd;
          end
          mq[k].push_back(t);
          fresh[k] = 0;
        end
      end
    end
  endtask

  task automatic cycle();
    #1 check_all();
    @(posedge CP);
    model_edge();
    @(negedge CP);
  endtask

  task automatic drive(input logic s, input logic [1:0] o, input logic [39:0] p, input logic [15:0] w);
    send_in = s;
    op      = o;
    pkt_in  = p;
    wd      = w;
  endtask

  initial begin
    logic [39:0] t1, p1;
    mr = 1'b1; ack_in = 1'b1;
    drive(0, PASS, 40'h0, 16'h0);
    @(posedge CP);
    model_edge();
    @(negedge CP);
    mr = 1'b0;
    cycle();

    // give every address used later a known value in both memories
    for (int a = 0; a < 56; a++) begin
      int ad;
      ad = (a < 32) ? a : 1000 + a - 32;
      drive(1, STORE, {30'h0, 10'(ad)}, 16'($urandom));
      cycle();
    end
    drive(0, PASS, 40'h0, 16'h0);
    cycle();

    // store then back-to-back load of the same word
    drive(1, STORE, 40'h00000_0012, 16'hBEEF);
    cycle();
    drive(1, LOAD, 40'hA5A5A50012, 16'h0);
    cycle();
    #1 chk("t2_load_pkt", 0, pkt_a, 40'hA5A5A5BEEF);
    chk("t2_load_err", 0, err_a, 0);
    drive(0, PASS, 40'h0, 16'h0);
    cycle();

    // fetch-add wraps; old value returned; single bubble
    drive(1, STORE, 40'h7, 16'hFFFE);
    cycle();
    drive(1, FADD, 40'h7, 16'h0003);
    cycle();
    #1 chk("t3_old_value", 0, pkt_a[15:0], 16'hFFFE);
    chk("t3_bubble_ack", 0, ack_a, 0);
    drive(1, LOAD, 40'h7, 16'h0);
    cycle();
    #1 chk("t3_ack_after_bubble", 0, ack_a, 1);
    cycle();
    #1 chk("t3_wrapped_sum", 0, pkt_a[15:0], 16'h0001);
    drive(0, PASS, 40'h0, 16'h0);
    cycle();

    // stall for four cycles, then stream at full rate
    t1 = {$urandom(), 8'h05};
    drive(1, PASS, t1, 16'h0);
    cycle();
    ack_in = 1'b0;
    drive(1, PASS, {$urandom(), 8'h09}, 16'h0);
    for (int i = 0; i < 4; i++) begin
      cycle();
      #1 chk("t4_stall_hold", 0, pkt_a, t1);
      chk("t4_stall_ack", 0, ack_a, 0);
    end
    ack_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      drive(1, 2'($urandom_range(0, 2)), {$urandom(), 3'b0, 5'($urandom_range(0, 31))}, 16'($urandom));
    end
    drive(0, PASS, 40'h0, 16'h0);
    cycle();

    // out-of-range handling in the DEPTH=1000 instance
    p1 = 40'hC0FFEE_03E8;
    drive(1, STORE, p1, 16'h1234);
    cycle();
    #1 chk("t5_store_err", 0, err_a, 1);
    chk("t5_store_pass", 0, pkt_a, p1);
    chk("t5_store_err_in_range", 1, err_b, 0);
    drive(1, LOAD, 40'h123456_03E8, 16'h0);
    cycle();
    #1 chk("t5_load_err", 0, err_a, 1);
    chk("t5_load_zero", 0, pkt_a[15:0], 16'h0000);
    chk("t5_load_in_range", 1, pkt_b[15:0], 16'h1234);
    drive(1, PASS, 40'h777777_03E8, 16'h0);
    cycle();
    #1 chk("t5_pass_no_err", 0, err_a, 0);
    drive(0, PASS, 40'h0, 16'h0);
    cycle();

    // random traffic, including occasional resets
    for (int i = 0; i < 400; i++) begin
      logic [1:0] o;
      int ad;
      o  = 2'($urandom_range(0, 3));
      ad = ($urandom_range(0, 3) != 0) ? $urandom_range(0, 31) : 1000 + $urandom_range(0, 23);
      if (o == FADD && ad >= 1000) o = LOAD;
      mr     = ($urandom_range(0, 63) == 0);
      ack_in = ($urandom_range(0, 3) != 0);
      drive($urandom_range(0, 4) != 0, o, {$urandom(), 6'($urandom), 10'(ad)}, 16'($urandom));
      cycle();
    end

    // reset with a token in flight
    mr = 1'b0; ack_in = 1'b0;
    drive(1, PASS, 40'hDEAD_0001, 16'h0);
    cycle();
    mr = 1'b1;
    cycle();
    mr = 1'b0; ack_in = 1'b1;
    #1 chk("t1_reset_send", 0, send_a, 0);
    chk("t1_reset_pkt", 0, pkt_a, 40'h0);
    chk("t1_reset_ack", 0, ack_a, 1);
    drive(1, LOAD, 40'h5, 16'h0);
    cycle();
    #1 chk("t1_cleared_word", 0, pkt_a[15:0], 16'h0000);
    drive(0, PASS, 40'h0, 16'h0);
    cycle();

    // reset during the fetch-add bubble suppresses the write-back
    drive(1, STORE, 40'h3, 16'h0010);
    cycle();
    drive(1, FADD, 40'h3, 16'h0001);
    cycle();
    mr = 1'b1;
    drive(0, PASS, 40'h0, 16'h0);
    cycle();
    mr = 1'b0;
    drive(1, LOAD, 40'h3, 16'h0);
    cycle();
    #1 chk("t6_write_suppressed", 1, pkt_b[15:0], 16'h0010);
    chk("t6_cleared", 0, pkt_a[15:0], 16'h0000);
    drive(0, PASS, 40'h0, 16'h0);
    cycle();
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
